// File: rtl/rx_cmd_pkg.sv
// rtl/rx_cmd_pkg.sv - shared constants, state type and hex helper for rx_cmd_parser
//
// Purpose: ASCII control characters, the parser state enum and a helper
//          that maps an ASCII hex digit to its 4-bit value.
// Ports:   none (package).
package rx_cmd_pkg;

  localparam logic [7:0] CR  = 8'h0D;
  localparam logic [7:0] LF  = 8'h0A;
  localparam logic [7:0] SP  = 8'h20;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] DEL = 8'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARG  = 2'd1,
    SKIP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Non-hex input maps to 0; callers qualify with their own is_hex flag.
  // 'A'/'a' have low nibble 1, so adding 9 yields 10 for both cases.
  function automatic logic [3:0] hex_nibble(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return c[3:0] + 4'd9;
    else
      return 4'd0;
  endfunction

endpackage

// File: rtl/ascii_classify.sv
// rtl/ascii_classify.sv - combinational classifier for one received ASCII byte
//
// Purpose: decode a byte into the character classes the parser cares about.
// Ports:
//   d         in  8  received ASCII byte
//   is_letter out 1  a-z or A-Z
//   is_hex    out 1  0-9, a-f or A-F
//   is_space  out 1  0x20
//   is_term   out 1  CR or LF
//   is_bs     out 1  backspace (0x08) or delete (0x7F)
//   nibble    out 4  hex value of d (0 when not hex)
//   upper     out 8  d with lowercase letters folded to uppercase
module ascii_classify
  import rx_cmd_pkg::*;
(
  input  logic [7:0] d,
  output logic       is_letter,
  output logic       is_hex,
  output logic       is_space,
  output logic       is_term,
  output logic       is_bs,
  output logic [3:0] nibble,
  output logic [7:0] upper
);

  logic is_lower;
  logic is_upper;
  logic is_digit;

  always_comb begin
    is_lower  = (d >= 8'h61) && (d <= 8'h7A);
    is_upper  = (d >= 8'h41) && (d <= 8'h5A);
    is_digit  = (d >= 8'h30) && (d <= 8'h39);
    is_letter = is_lower || is_upper;
    is_hex    = is_digit || ((d >= 8'h41) && (d <= 8'h46)) || ((d >= 8'h61) && (d <= 8'h66));
    is_space  = (d == SP);
    is_term   = (d == CR) || (d == LF);
    is_bs     = (d == BS) || (d == DEL);
    nibble    = hex_nibble(d);
    // Lowercase and uppercase ASCII letters differ only in bit 5.
    upper     = is_lower ? {d[7:6], 1'b0, d[4:0]} : d;
  end

endmodule

// File: rtl/rx_cmd_parser.sv
// rtl/rx_cmd_parser.sv - assembles received ASCII lines into debug commands
//
// Purpose: consume bytes from the UART receiver, build one command per line
//          (letter + optional hex argument + error flag) and present it to the
//          debug controller through a valid/ready handshake.
// Optional feature: define RX_CMD_BACKSPACE_EN to let 0x08/0x7F edit the
//          argument (or cancel the command letter) while in ARG.
// Ports:
//   clk         in   1      system clock
//   rst         in   1      synchronous reset, active-high
//   vld_rx      in   1      receiver has a byte waiting
//   rdy_rx      out  1      parser accepts a byte this cycle (state only)
//   d_rx        in   8      received ASCII byte
//   cmd_vld     out  1      a complete command is presented
//   cmd_rdy     in   1      controller takes the command
//   cmd_op      out  8      uppercase command letter, 0x00 for illegal start
//   cmd_arg     out  ARG_W  parsed hex argument, right-aligned
//   cmd_has_arg out  1      at least one hex digit was received
//   cmd_err     out  1      line was malformed
module rx_cmd_parser
  import rx_cmd_pkg::*;
#(
  parameter int ARG_W   = 32,
  parameter int MAX_DIG = ARG_W / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_rx,
  output logic             rdy_rx,
  input  logic [7:0]       d_rx,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic [7:0]       cmd_op,
  output logic [ARG_W-1:0] cmd_arg,
  output logic             cmd_has_arg,
  output logic             cmd_err
);

  localparam int CNT_W = $clog2(MAX_DIG + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIG);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             take;

  logic       is_letter;
  logic       is_hex;
  logic       is_space;
  logic       is_term;
  logic       is_bs;
  logic [3:0] nibble;
  logic [7:0] upper;

  ascii_classify u_classify (
    .d         (d_rx),
    .is_letter (is_letter),
    .is_hex    (is_hex),
    .is_space  (is_space),
    .is_term   (is_term),
    .is_bs     (is_bs),
    .nibble    (nibble),
    .upper     (upper)
  );

  // Backpressure toward the receiver only while a command is waiting.
  assign rdy_rx = (state != DONE);
  assign take   = vld_rx && rdy_rx;

  // cmd_arg doubles as the accumulator; it is only meaningful while cmd_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      cmd_vld     <= 1'b0;
      cmd_op      <= 8'h00;
      cmd_arg     <= '0;
      cmd_has_arg <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            if (is_space || is_term) begin
              // blank lines and CR LF tails are skipped
            end else if (is_letter) begin
              cmd_op  <= upper;
              cmd_arg <= '0;
              count   <= '0;
              state   <= ARG;
            end else begin
              cmd_op <= 8'h00;
              state  <= SKIP;
            end
          end
        end

        ARG: begin
          if (take) begin
            if (is_space) begin
              // spaces between letter and digits are ignored
            end else if (is_hex) begin
              if (count == MAX_CNT) begin
                state <= SKIP;
              end else begin
                cmd_arg <= {cmd_arg[ARG_W-5:0], nibble};
                count   <= count + 1'b1;
              end
            end else if (is_term) begin
              cmd_has_arg <= (count != '0);
              cmd_err     <= 1'b0;
              cmd_vld     <= 1'b1;
              state       <= DONE;
`ifdef RX_CMD_BACKSPACE_EN
            end else if (is_bs) begin
              if (count != '0) begin
                cmd_arg <= cmd_arg >> 4;
                count   <= count - 1'b1;
              end else begin
                // erasing past the first digit cancels the command letter
                cmd_op <= 8'h00;
                state  <= IDLE;
              end
`else
            end else if (is_bs) begin
              state <= SKIP;
`endif
            end else begin
              state <= SKIP;
            end
          end
        end

        SKIP: begin
          if (take && is_term) begin
            cmd_err     <= 1'b1;
            cmd_has_arg <= 1'b0;
            cmd_arg     <= '0;
            cmd_vld     <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (cmd_rdy) begin
            cmd_vld <= 1'b0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_cmd_parser.sv
// tb/tb_rx_cmd_parser.sv - self-checking bench for rx_cmd_parser
module tb_rx_cmd_parser;

  localparam int MAXD = 8;

  typedef logic [7:0] u8;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] arg;
    logic        has;
    logic        err;
  } cmd_t;

  typedef struct {
    string       s;
    logic [7:0]  op;
    logic [31:0] arg;
    logic        has;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld_rx;
  logic        rdy_rx;
  logic [7:0]  d_rx;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic [7:0]  cmd_op;
  logic [31:0] cmd_arg;
  logic        cmd_has_arg;
  logic        cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  u8    tx_q[$];
  cmd_t rx_q[$];
  cmd_t exp_q[$];

  rx_cmd_parser #(.ARG_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_rx      (vld_rx),
    .rdy_rx      (rdy_rx),
    .d_rx        (d_rx),
    .cmd_vld     (cmd_vld),
    .cmd_rdy     (cmd_rdy),
    .cmd_op      (cmd_op),
    .cmd_arg     (cmd_arg),
    .cmd_has_arg (cmd_has_arg),
    .cmd_err     (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) tx_q.push_back(u8'(s[i]));
  endfunction

  // ---------------- reference model (line oriented) ----------------
  function automatic bit m_alpha(input u8 c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic int m_hexval(input u8 c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  function automatic void model_line(input u8 line[$]);
    int   k = 0;
    int   digits = 0;
    bit   bad = 0;
    longint val = 0;
    cmd_t c;
    while (k < line.size() && line[k] == 8'h20) k++;
    if (k == line.size()) return;
    c = '0;
    if (!m_alpha(line[k])) begin
      c.err = 1'b1;
      exp_q.push_back(c);
      return;
    end
    c.op = (line[k] >= "a") ? line[k] - 8'd32 : line[k];
    for (int j = k + 1; j < line.size(); j++) begin
      if (line[j] == 8'h20) continue;
      if (m_hexval(line[j]) < 0) bad = 1;
      else begin
        digits++;
        val = val * 16 + m_hexval(line[j]);
      end
    end
    if (bad || digits > MAXD) c.err = 1'b1;
    else begin
      c.has = (digits > 0);
      c.arg = val[31:0];
    end
    exp_q.push_back(c);
  endfunction

  function automatic void model_stream(input u8 s[$]);
    u8 line[$];
    foreach (s[i]) begin
      if (s[i] == 8'h0D || s[i] == 8'h0A) begin
        model_line(line);
        line.delete();
      end else begin
        line.push_back(s[i]);
      end
    end
  endfunction

  // ---------------- stream driver / command collector ----------------
  task automatic run_stream(input int rdy_pct, input int vld_pct, input bit stop_at_cmd, input int budget);
    int cyc = 0;
    int tail = 0;
    bit acc;
    bit take;
    while (cyc < budget) begin
      if (stop_at_cmd && cmd_vld && tx_q.size() == 0) break;
      if (!stop_at_cmd && tx_q.size() == 0 && !cmd_vld) begin
        if (tail == 4) break;
        tail++;
      end
      vld_rx  = (tx_q.size() > 0) && ($urandom_range(99) < vld_pct);
      d_rx    = vld_rx ? tx_q[0] : 8'h00;
      cmd_rdy = ($urandom_range(99) < rdy_pct);
      acc  = vld_rx && rdy_rx;
      take = cmd_vld && cmd_rdy;
      if (take) rx_q.push_back(cmd_t'{cmd_op, cmd_arg, cmd_has_arg, cmd_err});
      @(posedge clk);
      #1;
      if (acc) void'(tx_q.pop_front());
      cyc++;
    end
    vld_rx  = 1'b0;
    cmd_rdy = 1'b0;
    if (cyc >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d cycles, expected under %0d", cyc, budget);
      tx_q.delete();
    end
  endtask

  task automatic gen_line();
    string letters = "RWgsAbfQzx";
    string illeg   = "#5@";
    string hexs    = "0123456789abcdefABCDEF";
    string junk    = "G#\011";
    int    r;
    int    nd;
    if ($urandom_range(9) != 0) begin
      repeat ($urandom_range(2)) tx_q.push_back(8'h20);
      if ($urandom_range(9) < 8) tx_q.push_back(u8'(letters[$urandom_range(letters.len() - 1)]));
      else tx_q.push_back(u8'(illeg[$urandom_range(illeg.len() - 1)]));
      nd = $urandom_range(10);
      for (int i = 0; i < nd; i++) begin
        r = $urandom_range(19);
        if (r == 0) tx_q.push_back(u8'(junk[$urandom_range(junk.len() - 1)]));
        else if (r < 3) tx_q.push_back(8'h20);
        else tx_q.push_back(u8'(hexs[$urandom_range(hexs.len() - 1)]));
      end
    end
    r = $urandom_range(2);
    if (r == 0) tx_q.push_back(8'h0D);
    else if (r == 1) tx_q.push_back(8'h0A);
    else begin
      tx_q.push_back(8'h0D);
      tx_q.push_back(8'h0A);
    end
  endtask

  vec_t vecs[10];
  cmd_t snap;

  initial begin
    vecs[0] = '{"R 1A2B\015",        8'h52, 32'h00001A2B, 1'b1, 1'b0};
    vecs[1] = '{"g\015\012",         8'h47, 32'h0,        1'b0, 1'b0};
    vecs[2] = '{"W 123456789\015",   8'h57, 32'h0,        1'b0, 1'b1};
    vecs[3] = '{"W 12345678\015",    8'h57, 32'h12345678, 1'b1, 1'b0};
    vecs[4] = '{"R 1G\015",          8'h52, 32'h0,        1'b0, 1'b1};
    vecs[5] = '{"#5\012",            8'h00, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{"\015\012  b c\012", 8'h42, 32'h0000000C, 1'b1, 1'b0};
    vecs[7] = '{"q 1 2 3\015",       8'h51, 32'h00000123, 1'b1, 1'b0};
    vecs[8] = '{"z FFFFFFFF\012",    8'h5A, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[9] = '{"x\011\015",         8'h58, 32'h0,        1'b0, 1'b1};

    rst = 1'b1; vld_rx = 1'b0; d_rx = 8'h00; cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset cmd_vld", cmd_vld, 0);
    check("reset cmd_op", cmd_op, 0);
    check("reset cmd_arg", cmd_arg, 0);
    check("reset cmd_has_arg", cmd_has_arg, 0);
    check("reset cmd_err", cmd_err, 0);
    check("reset rdy_rx", rdy_rx, 1);
    rst = 1'b0;

    // table-driven lines, one command each
    for (int i = 0; i < 10; i++) begin
      rx_q.delete();
      push_str(vecs[i].s);
      run_stream(100, 100, 1'b0, 400);
      check($sformatf("vec%0d count", i), rx_q.size(), 1);
      if (rx_q.size() > 0) begin
        check($sformatf("vec%0d op", i), rx_q[0].op, vecs[i].op);
        check($sformatf("vec%0d arg", i), rx_q[0].arg, vecs[i].arg);
        check($sformatf("vec%0d has_arg", i), rx_q[0].has, vecs[i].has);
        check($sformatf("vec%0d err", i), rx_q[0].err, vecs[i].err);
      end
    end

    // backpressure: command held while 'S' waits on the receiver
    rx_q.delete();
    push_str("g\015");
    run_stream(0, 100, 1'b1, 100);
    snap = cmd_t'{cmd_op, cmd_arg, cmd_has_arg, cmd_err};
    check("bp cmd_vld up", cmd_vld, 1);
    for (int i = 0; i < 20; i++) begin
      vld_rx = 1'b1; d_rx = "S"; cmd_rdy = 1'b0;
      check($sformatf("bp rdy_rx c%0d", i), rdy_rx, 0);
      @(posedge clk);
      #1;
      check($sformatf("bp stable c%0d", i), {cmd_vld, cmd_op, cmd_arg, cmd_has_arg, cmd_err}, {1'b1, snap});
    end
    cmd_rdy = 1'b1;
    check("bp rdy_rx at cmd_rdy", rdy_rx, 0);
    @(posedge clk);
    #1;
    cmd_rdy = 1'b0;
    check("bp cmd_vld fell", cmd_vld, 0);
    check("bp rdy_rx idle", rdy_rx, 1);
    @(posedge clk);
    #1;
    vld_rx = 1'b0;
    push_str("\015");
    run_stream(100, 100, 1'b0, 100);
    check("bp S count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("bp S cmd", rx_q[0], cmd_t'{8'h53, 32'h0, 1'b0, 1'b0});

    // reset in the middle of a line
    rx_q.delete();
    push_str("R 12");
    run_stream(100, 100, 1'b0, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_str("S\015");
    run_stream(100, 100, 1'b0, 100);
    check("midrst count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("midrst cmd", rx_q[0], cmd_t'{8'h53, 32'h0, 1'b0, 1'b0});

`ifdef RX_CMD_BACKSPACE_EN
    rx_q.delete();
    push_str("R 12\010\015");
    run_stream(100, 100, 1'b0, 100);
    check("bs count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("bs cmd", rx_q[0], cmd_t'{8'h52, 32'h1, 1'b1, 1'b0});
`else
    rx_q.delete();
    push_str("R 12\010\015");
    run_stream(100, 100, 1'b0, 100);
    check("bs illegal count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("bs illegal cmd", rx_q[0], cmd_t'{8'h52, 32'h0, 1'b0, 1'b1});
`endif

    // randomized streams against the line model
    for (int r = 0; r < 8; r++) begin
      u8 stream[$];
      rx_q.delete();
      exp_q.delete();
      repeat (8) gen_line();
      stream = tx_q;
      model_stream(stream);
      run_stream(60, 70, 1'b0, 3000);
      check($sformatf("rand%0d count", r), rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
        check($sformatf("rand%0d cmd%0d", r, i), rx_q[i], exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
